// File: rtl/audio_out_arbiter_if.sv
// Bundle between the sample sources, the arbiter and the DE2 audio controller.
// The master modport is the arbiter side; slave is the sources/controller side.
interface audio_out_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            sample_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] left_in;
    logic [NUM_REQ*DATA_WIDTH-1:0] right_in;
    logic                          audio_out_allowed;
    logic [NUM_REQ-1:0]            grant;
    logic [NUM_REQ-1:0]            sample_ack;
    logic                          write_audio_out;
    logic [DATA_WIDTH-1:0]         left_channel_audio_out;
    logic [DATA_WIDTH-1:0]         right_channel_audio_out;
    logic                          clear_audio_out_memory;
    logic                          busy;

    modport master (
        input  req, sample_valid, left_in, right_in, audio_out_allowed,
        output grant, sample_ack, write_audio_out, left_channel_audio_out,
               right_channel_audio_out, clear_audio_out_memory, busy
    );

    modport slave (
        output req, sample_valid, left_in, right_in, audio_out_allowed,
        input  grant, sample_ack, write_audio_out, left_channel_audio_out,
               right_channel_audio_out, clear_audio_out_memory, busy
    );
endinterface

// File: rtl/audio_out_arbiter.sv
// Round-robin stream arbiter sharing the DE2 audio output path among NUM_REQ sources,
// pacing writes against audio_out_allowed and aborting grants that exceed MAX_BURST.
module audio_out_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 48000
) (
    input logic                 CLOCK_50,
    input logic                 reset,
    audio_out_arbiter_if.master bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_GRANTED = 3'd1;
    localparam logic [2:0] S_WRITE   = 3'd2;
    localparam logic [2:0] S_SETTLE  = 3'd3;
    localparam logic [2:0] S_ABORT   = 3'd4;

    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);
    localparam logic [IDX_W-1:0] LAST_INIT   = IDX_W'(NUM_REQ - 1);

    logic [2:0]            state;
    logic [IDX_W-1:0]      owner;
    logic [IDX_W-1:0]      last;
    logic [NUM_REQ-1:0]    lockout;
    logic [CNT_W-1:0]      burst_cnt;
    logic [NUM_REQ-1:0]    grant_q;
    logic [NUM_REQ-1:0]    ack_q;
    logic                  write_q;
    logic                  clear_q;
    logic                  busy_q;
    logic [DATA_WIDTH-1:0] left_q;
    logic [DATA_WIDTH-1:0] right_q;

    logic [NUM_REQ-1:0]    eligible;
    logic                  win_found;
    logic [IDX_W-1:0]      win_idx;
    logic [NUM_REQ-1:0]    lockout_set;
    logic [DATA_WIDTH-1:0] lane_left;
    logic [DATA_WIDTH-1:0] lane_right;

    function automatic logic [NUM_REQ-1:0] to_onehot(input logic [IDX_W-1:0] idx);
        to_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Returns {found, index}; scan starts one past the previous owner.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                               input logic [IDX_W-1:0]   prev);
        logic             found;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] cand;
        found = 1'b0;
        idx   = {IDX_W{1'b0}};
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(prev) + k) % NUM_REQ);
            if (!found && elig[cand]) begin
                found = 1'b1;
                idx   = cand;
            end else begin
                idx   = idx;
            end
        end
        rr_pick = {found, idx};
    endfunction

    // Arbitration candidates, owner lane data and the lockout set request.
    always_comb begin
        eligible               = bus.req & ~lockout;
        {win_found, win_idx}   = rr_pick(eligible, last);
        lane_left              = bus.left_in[int'(owner) * DATA_WIDTH +: DATA_WIDTH];
        lane_right             = bus.right_in[int'(owner) * DATA_WIDTH +: DATA_WIDTH];
        if (state == S_ABORT) begin
            lockout_set = to_onehot(owner);
        end else begin
            lockout_set = {NUM_REQ{1'b0}};
        end
    end

    // Main FSM with all outputs registered; strobes default low every cycle.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state     <= S_IDLE;
            owner     <= {IDX_W{1'b0}};
            last      <= LAST_INIT;
            lockout   <= {NUM_REQ{1'b0}};
            burst_cnt <= {CNT_W{1'b0}};
            grant_q   <= {NUM_REQ{1'b0}};
            ack_q     <= {NUM_REQ{1'b0}};
            write_q   <= 1'b0;
            clear_q   <= 1'b0;
            busy_q    <= 1'b0;
            left_q    <= {DATA_WIDTH{1'b0}};
            right_q   <= {DATA_WIDTH{1'b0}};
        end else begin
            write_q <= 1'b0;
            ack_q   <= {NUM_REQ{1'b0}};
            clear_q <= 1'b0;
            // A dropped request clears its lockout even if one is being set.
            lockout <= (lockout | lockout_set) & bus.req;

            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        grant_q   <= to_onehot(win_idx);
                        owner     <= win_idx;
                        burst_cnt <= {CNT_W{1'b0}};
                        busy_q    <= 1'b1;
                        state     <= S_GRANTED;
                    end else begin
                        grant_q   <= {NUM_REQ{1'b0}};
                        busy_q    <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                S_GRANTED: begin
                    if (!bus.req[owner]) begin
                        last    <= owner;
                        grant_q <= {NUM_REQ{1'b0}};
                        busy_q  <= 1'b0;
                        state   <= S_IDLE;
                    end else if (burst_cnt == BURST_LIMIT) begin
                        grant_q <= {NUM_REQ{1'b0}};
                        clear_q <= 1'b1;
                        state   <= S_ABORT;
                    end else if (bus.sample_valid[owner] && bus.audio_out_allowed) begin
                        left_q    <= lane_left;
                        right_q   <= lane_right;
                        burst_cnt <= burst_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                        write_q   <= 1'b1;
                        ack_q     <= to_onehot(owner);
                        state     <= S_WRITE;
                    end else begin
                        state     <= S_GRANTED;
                    end
                end
                S_WRITE: begin
                    state <= S_SETTLE;
                end
                // Gives the controller's registered allowed flag time to reflect the write.
                S_SETTLE: begin
                    state <= S_GRANTED;
                end
                S_ABORT: begin
                    last   <= owner;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    grant_q <= {NUM_REQ{1'b0}};
                    busy_q  <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.grant                   = grant_q;
    assign bus.sample_ack              = ack_q;
    assign bus.write_audio_out         = write_q;
    assign bus.left_channel_audio_out  = left_q;
    assign bus.right_channel_audio_out = right_q;
    assign bus.clear_audio_out_memory  = clear_q;
    assign bus.busy                    = busy_q;
endmodule

// File: tb/tb_audio_out_arbiter.sv
// Directed bench for audio_out_arbiter: a cycle-by-cycle vector table plus
// hand sequences for round-robin order, backpressure, release/accept race and reset.
module tb_audio_out_arbiter;
    localparam int NR = 4;
    localparam int DW = 32;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    audio_out_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    audio_out_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (bus)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] sv;
        logic       al;
        logic [3:0] e_grant;
        logic [3:0] e_ack;
        logic       e_wr;
        logic       e_clr;
        logic       e_busy;
        int         e_lane;
    } vec_t;

    vec_t vq[$];
    int   tests = 0;
    int   fails = 0;

    function automatic logic [31:0] lane_l(input int i);
        if (i < 0) return 32'h0;
        return 32'h0000_1234 + (32'(i) << 16);
    endfunction

    function automatic logic [31:0] lane_r(input int i);
        if (i < 0) return 32'h0;
        return 32'h0000_5678 + (32'(i) << 16);
    endfunction

    task automatic add_v(input logic rst, input logic [3:0] req, input logic [3:0] sv,
                         input logic al, input logic [3:0] g, input logic [3:0] ack,
                         input logic wr, input logic clr, input logic bsy, input int lane);
        vec_t v;
        v.rst = rst; v.req = req; v.sv = sv; v.al = al;
        v.e_grant = g; v.e_ack = ack; v.e_wr = wr; v.e_clr = clr;
        v.e_busy = bsy; v.e_lane = lane;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req = 4'b0000;
        bus.sample_valid = 4'b0000;
        bus.audio_out_allowed = 1'b0;
        step();
        reset = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int order[4];
        int n;
        int writes;
        int g;
        int seen;

        reset = 1'b1;
        bus.req = 4'b0000;
        bus.sample_valid = 4'b0000;
        bus.audio_out_allowed = 1'b0;
        for (int i = 0; i < NR; i++) begin
            bus.left_in[i*DW +: DW]  = lane_l(i);
            bus.right_in[i*DW +: DW] = lane_r(i);
        end

        //    rst  req      sv       al    grant    ack      wr    clr   busy  lane
        add_v(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, -1);
        add_v(1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1, -1);
        add_v(1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b1, 0);
        add_v(1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1, 0);
        add_v(1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1, 0);
        add_v(1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b1, 0);
        add_v(1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1, 0);
        add_v(1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1, 0);
        add_v(1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b1, 0);
        add_v(1'b0, 4'b0000, 4'b0001, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1, 0);
        add_v(1'b0, 4'b0000, 4'b0001, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1, 0);
        add_v(1'b0, 4'b0000, 4'b0001, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 0);
        // source 1 streams into the limit while source 2 waits
        add_v(1'b0, 4'b0110, 4'b0110, 1'b1, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b1, 0);
        for (int w = 0; w < 4; w++) begin
            add_v(1'b0, 4'b0110, 4'b0110, 1'b1, 4'b0010, 4'b0010, 1'b1, 1'b0, 1'b1, 1);
            add_v(1'b0, 4'b0110, 4'b0110, 1'b1, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b1, 1);
            add_v(1'b0, 4'b0110, 4'b0110, 1'b1, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b1, 1);
        end
        add_v(1'b0, 4'b0110, 4'b0110, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 1);
        add_v(1'b0, 4'b0110, 4'b0110, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1);
        add_v(1'b0, 4'b0110, 4'b0110, 1'b1, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b1, 1);
        // owner 2 drops req while its sample is valid and allowed: no write
        add_v(1'b0, 4'b0010, 4'b0110, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1);
        add_v(1'b0, 4'b0010, 4'b0010, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1);
        add_v(1'b0, 4'b0000, 4'b0010, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1);
        add_v(1'b0, 4'b0010, 4'b0010, 1'b1, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b1, 1);
        add_v(1'b0, 4'b0000, 4'b0010, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1);

        foreach (vq[i]) begin
            reset                 = vq[i].rst;
            bus.req               = vq[i].req;
            bus.sample_valid      = vq[i].sv;
            bus.audio_out_allowed = vq[i].al;
            step();
            chk($sformatf("v%0d_grant", i), bus.grant, vq[i].e_grant);
            chk($sformatf("v%0d_ack", i), bus.sample_ack, vq[i].e_ack);
            chk($sformatf("v%0d_write", i), bus.write_audio_out, vq[i].e_wr);
            chk($sformatf("v%0d_clear", i), bus.clear_audio_out_memory, vq[i].e_clr);
            chk($sformatf("v%0d_busy", i), bus.busy, vq[i].e_busy);
            chk($sformatf("v%0d_left", i), bus.left_channel_audio_out, lane_l(vq[i].e_lane));
            chk($sformatf("v%0d_right", i), bus.right_channel_audio_out, lane_r(vq[i].e_lane));
        end

        // Round-robin: req=1011, each owner releases after two samples
        do_reset();
        order[0] = 0; order[1] = 1; order[2] = 3; order[3] = 0;
        bus.req = 4'b1011;
        bus.sample_valid = 4'b1011;
        bus.audio_out_allowed = 1'b1;
        for (int r = 0; r < 4; r++) begin
            g = order[r];
            n = 0;
            while (bus.grant == 4'b0000 && n < 20) begin
                step();
                n++;
            end
            chk($sformatf("rr%0d_grant", r), bus.grant, 64'(1) << g);
            writes = 0;
            n = 0;
            while (writes < 2 && n < 30) begin
                step();
                n++;
                if (bus.write_audio_out) begin
                    writes++;
                    chk($sformatf("rr%0d_ack", r), bus.sample_ack, 64'(1) << g);
                end
            end
            chk($sformatf("rr%0d_writes", r), writes, 2);
            bus.req[g] = 1'b0;
            n = 0;
            while (bus.grant != 4'b0000 && n < 20) begin
                step();
                n++;
            end
            chk($sformatf("rr%0d_release", r), bus.grant, 0);
            bus.req[g] = 1'b1;
        end

        // Backpressure on owner 2
        do_reset();
        bus.req = 4'b0100;
        bus.sample_valid = 4'b0100;
        bus.audio_out_allowed = 1'b0;
        step();
        chk("bp_grant", bus.grant, 4'b0100);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (bus.write_audio_out || (bus.sample_ack != 4'b0000)) seen++;
        end
        chk("bp_stalled", seen, 0);
        bus.audio_out_allowed = 1'b1;
        step();
        chk("bp_write", bus.write_audio_out, 1'b1);
        chk("bp_ack", bus.sample_ack, 4'b0100);
        chk("bp_left", bus.left_channel_audio_out, lane_l(2));
        chk("bp_right", bus.right_channel_audio_out, lane_r(2));
        bus.audio_out_allowed = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (bus.write_audio_out) seen++;
        end
        chk("bp_single_write", seen, 0);

        // Release in the same cycle the accept condition appears
        do_reset();
        bus.req = 4'b0001;
        bus.sample_valid = 4'b0001;
        step();
        step();
        bus.req = 4'b0000;
        bus.audio_out_allowed = 1'b1;
        step();
        chk("race_write", bus.write_audio_out, 1'b0);
        chk("race_ack", bus.sample_ack, 4'b0000);
        chk("race_grant", bus.grant, 4'b0000);
        chk("race_busy", bus.busy, 1'b0);

        // Reset asserted while in WRITE
        do_reset();
        bus.req = 4'b0001;
        bus.sample_valid = 4'b0001;
        bus.audio_out_allowed = 1'b1;
        step();
        step();
        chk("mr_write_before", bus.write_audio_out, 1'b1);
        reset = 1'b1;
        step();
        chk("mr_grant", bus.grant, 4'b0000);
        chk("mr_ack", bus.sample_ack, 4'b0000);
        chk("mr_write", bus.write_audio_out, 1'b0);
        chk("mr_clear", bus.clear_audio_out_memory, 1'b0);
        chk("mr_busy", bus.busy, 1'b0);
        chk("mr_left", bus.left_channel_audio_out, 32'h0);
        chk("mr_right", bus.right_channel_audio_out, 32'h0);
        reset = 1'b0;
        bus.req = 4'b1000;
        bus.sample_valid = 4'b1000;
        step();
        chk("mr_grant3", bus.grant, 4'b1000);
        step();
        chk("mr_write3", bus.write_audio_out, 1'b1);
        chk("mr_ack3", bus.sample_ack, 4'b1000);
        chk("mr_left3", bus.left_channel_audio_out, lane_l(3));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/audio_out_arbiter.md
# audio_out_arbiter

Shares the single audio output path of the DE2 audio controller (left/right sample inputs, `write_audio_out`, `audio_out_allowed`, `clear_audio_out_memory`) among `NUM_REQ` sample sources, such as the alert tone generator and voice clip player. It grants whole streams in round-robin order. It paces sample writes against `audio_out_allowed` and enforces a per-grant sample limit. When a source hits that limit, the arbiter forcibly ends its grant and flushes the output FIFOs.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_WIDTH`, 32: sample width per channel.
- `MAX_BURST`, 48000: maximum samples accepted per grant before abort. Counter width is `$clog2(MAX_BURST+1)`.
- `CLOCK_50` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `req` in `NUM_REQ`: level request from each source. It is held for the whole stream.
- `sample_valid` in `NUM_REQ`: source has a sample on its data lanes. Data must be held until `sample_ack`.
- `left_in` in `NUM_REQ*DATA_WIDTH`: packed left samples. Lane i is `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `right_in` in `NUM_REQ*DATA_WIDTH`: packed right samples, same lane layout as `left_in`.
- `audio_out_allowed` in 1: from the audio controller; both output FIFOs have space.
- `grant` out `NUM_REQ`: one-hot or zero; the current owner.
- `sample_ack` out `NUM_REQ`: 1-cycle pulse when a sample is taken from that source.
- `write_audio_out` out 1: 1-cycle write strobe to the audio controller.
- `left_channel_audio_out` out `DATA_WIDTH`: latched left sample.
- `right_channel_audio_out` out `DATA_WIDTH`: latched right sample.
- `clear_audio_out_memory` out 1: 1-cycle FIFO flush pulse on abort.
- `busy` out 1: high whenever the state is not IDLE.

## Operation

**States:** IDLE, GRANTED, WRITE, SETTLE, ABORT.

**IDLE**
- `grant=0`.
- If any eligible `req` bit is set, pick the winner by round-robin, starting at `(last+1) mod NUM_REQ`.
- Set `grant` to the winner, clear `burst_cnt`, then go to GRANTED.
- Eligible means `req[i]=1` and `lockout[i]=0`.

**GRANTED** (owner g)
- Rules are evaluated in this priority order:
  1. If `req[g]=0`: set `last=g`, go to IDLE.
  2. Else if `burst_cnt==MAX_BURST`: go to ABORT.
  3. Else if `sample_valid[g] & audio_out_allowed`: latch lane g into both output data registers, increment `burst_cnt`, go to WRITE.

**WRITE** (1 cycle)
- `write_audio_out=1` and `sample_ack[g]=1`.
- Go to SETTLE.

**SETTLE** (1 cycle)
- No write; this covers the 2-cycle lag of the registered `audio_out_allowed`.
- Go to GRANTED.

**ABORT** (1 cycle)
- `clear_audio_out_memory=1`, `grant=0`, set `lockout[g]=1`, set `last=g`.
- Go to IDLE.

**Lockout and data**
- `lockout[i]` clears on any cycle in which `req[i]=0`.
- Output data registers hold their last value outside WRITE; they are never cleared except by reset.

**Boundaries**
- A `req` drop in the same cycle as an accept condition: the drop wins and the sample is not taken.
- Sample number `MAX_BURST` is accepted normally; the limit check on the next GRANTED visit triggers ABORT.
- All requesters locked out: stay in IDLE.
- Bits of `sample_valid` for non-owners are ignored.
- `reset` asserted mid-operation: next state is IDLE and all outputs take their reset values, with no flush pulse.

## Timing
- **Reset values:** state=IDLE, `grant=0`, `sample_ack=0`, `write_audio_out=0`, both data outputs 0, `clear_audio_out_memory=0`, `busy=0`, `lockout=0`, `last=NUM_REQ-1` (so requester 0 wins first), `burst_cnt=0`.
- All outputs are registered.
- **Request to grant:** `req` high at edge N gives `grant` valid after edge N+1.
- **Accept timing:** accept at GRANTED edge M gives `write_audio_out`, `sample_ack`, and data all valid together in cycle M+1.
- **Sample rate:** at most one sample per 3 cycles per grant.
- **Release:** `req` falling in GRANTED gives `grant=0` in the next cycle. A new grant takes effect one cycle later, so there is at least 1 idle cycle between owners.

## Test plan
- **Single source:** reset; `req[0]=1`, `sample_valid[0]=1`, `audio_out_allowed=1`, left=0x00001234, right=0x00005678 → `grant`=0001 one cycle later. Writes then occur every 3rd cycle, each carrying those values with `sample_ack[0]` coincident.
- **Round-robin:** `req`=1011 held. Each owner drops `req` after 2 samples and re-raises it 1 cycle later → grant order 0, 1, 3, 0.
- **Backpressure:** owner 2 valid, `audio_out_allowed=0` for 10 cycles → no `write_audio_out` and no `sample_ack`. When allowed rises, exactly one write occurs 1 cycle after GRANTED samples it.
- **Burst limit:** `MAX_BURST=4`, source 1 streams continuously → exactly 4 writes, then one `clear_audio_out_memory` pulse and `grant=0`. Source 1 is not re-granted until `req[1]` drops and rises again; source 2, if requesting, is granted next.
- **Simultaneous release/accept:** `req[g]` falls in the same cycle as `sample_valid[g]` with allowed high → no write and no ack; IDLE next.
- **Mid-stream reset:** `reset` asserted during WRITE → next cycle has all outputs 0 and the state in IDLE. The following `req[3]` alone is granted normally.
